// File: rtl/ahead_sub32_pipe_pkg.sv
// Shared constants, slice result type and 4-bit lookahead helper for the
// pipelined 32-bit lookahead subtractor.
package ahead_sub32_pipe_pkg;

    localparam int W  = 32;
    localparam int HW = 16;
    localparam int GW = 4;

    typedef struct packed {
        logic [HW-1:0] diff;
        logic          cout;
    } slice_t;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Group generate/propagate over one 4-bit lookahead group.
    function automatic gp_t group_gp(input logic [GW-1:0] g, input logic [GW-1:0] p);
        gp_t r;
        r.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        r.p = &p;
        return r;
    endfunction

endpackage

// File: rtl/ahead_sub32_pipe_if.sv
// Operand/result handshake bundle for the pipelined subtractor.
interface ahead_sub32_pipe_if;
    import ahead_sub32_pipe_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          bin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  diff;
    logic          bout;
    logic          ovf;
    logic          zero;

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf, zero
    );

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf, zero
    );

endinterface

// File: rtl/ahead_sub32_pipe_sub16.sv
// Combinational 16-bit carry-lookahead slice computing a + nb + cin, where the
// caller supplies the already-inverted subtrahend.
module ahead_sub16
    import ahead_sub32_pipe_pkg::*;
(
    input  logic [HW-1:0] a,
    input  logic [HW-1:0] nb,
    input  logic          cin,
    output logic [HW-1:0] d,
    output logic          cout
);

    localparam int NG = HW / GW;

    logic [HW-1:0] g;
    logic [HW-1:0] p;
    logic [NG:0]   gc;

    assign g     = a & nb;
    assign p     = a | nb;
    assign gc[0] = cin;
    assign cout  = gc[NG];

    genvar gi, gj;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_grp
            gp_t          gp;
            logic [GW-1:0] c;

            // Group carries come from lookahead; bits inside a group ripple
            // from the group carry-in.
            assign gp         = group_gp(g[gi*GW +: GW], p[gi*GW +: GW]);
            assign gc[gi+1]   = gp.g | (gp.p & gc[gi]);
            assign c[0]       = gc[gi];

            for (gj = 0; gj < GW-1; gj++) begin : g_bitc
                assign c[gj+1] = g[gi*GW+gj] | (p[gi*GW+gj] & c[gj]);
            end

            for (gj = 0; gj < GW; gj++) begin : g_sum
                assign d[gi*GW+gj] = a[gi*GW+gj] ^ nb[gi*GW+gj] ^ c[gj];
            end
        end
    endgenerate

endmodule

// File: rtl/ahead_sub32_pipe.sv
// Two-stage pipelined 32-bit subtractor (DIFF = A - B - BIN): low slice in
// stage 1, high slice plus flags in stage 2, valid/ready on both sides.
module ahead_sub32_pipe
    import ahead_sub32_pipe_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    ahead_sub32_pipe_if.slave  bus
);

    logic ready1;
    logic ready2;
    logic accept;

    logic [HW-1:0] lo_d;
    logic          lo_cout;
    slice_t        lo_next;
    logic [HW-1:0] hi_d;
    logic          hi_cout;
    logic [W-1:0]  diff_next;

    // Stage 1 state
    logic          v1_reg;
    slice_t        lo_reg;
    logic [HW-1:0] a_hi_reg;
    logic [HW-1:0] nb_hi_reg;
    logic          a31_reg;
    logic          b31_reg;

    // Stage 2 state
    logic          v2_reg;
    logic [W-1:0]  diff_reg;
    logic          bout_reg;
    logic          ovf_reg;
    logic          zero_reg;

    assign ready2       = ~v2_reg | bus.out_ready;
    assign ready1       = ~v1_reg | ready2;
    assign bus.in_ready = ready1 & ~rst;
    assign accept       = bus.in_valid & bus.in_ready;

    ahead_sub16 u_lo (
        .a    (bus.a[HW-1:0]),
        .nb   (~bus.b[HW-1:0]),
        .cin  (~bus.bin),
        .d    (lo_d),
        .cout (lo_cout)
    );

    assign lo_next.diff = lo_d;
    assign lo_next.cout = lo_cout;

    ahead_sub16 u_hi (
        .a    (a_hi_reg),
        .nb   (nb_hi_reg),
        .cin  (lo_reg.cout),
        .d    (hi_d),
        .cout (hi_cout)
    );

    assign diff_next = {hi_d, lo_reg.diff};

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg    <= 1'b0;
            lo_reg    <= '0;
            a_hi_reg  <= '0;
            nb_hi_reg <= '0;
            a31_reg   <= 1'b0;
            b31_reg   <= 1'b0;
            v2_reg    <= 1'b0;
            diff_reg  <= '0;
            bout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            zero_reg  <= 1'b0;
        end else begin
            if (ready1) begin
                v1_reg <= accept;
            end
            if (accept) begin
                lo_reg    <= lo_next;
                a_hi_reg  <= bus.a[W-1:HW];
                nb_hi_reg <= ~bus.b[W-1:HW];
                a31_reg   <= bus.a[W-1];
                b31_reg   <= bus.b[W-1];
            end
            if (ready2) begin
                v2_reg <= v1_reg;
            end
            // Result registers only move on a real beat so idle outputs hold.
            if (ready2 && v1_reg) begin
                diff_reg <= diff_next;
                bout_reg <= ~hi_cout;
                ovf_reg  <= (a31_reg ^ b31_reg) & (a31_reg ^ hi_d[HW-1]);
                zero_reg <= (diff_next == '0);
            end
        end
    end

    assign bus.out_valid = v2_reg;
    assign bus.diff      = diff_reg;
    assign bus.bout      = bout_reg;
    assign bus.ovf       = ovf_reg;
    assign bus.zero      = zero_reg;

endmodule

// File: tb/tb_ahead_sub32_pipe.sv
// Randomized and directed bench for ahead_sub32_pipe with an arithmetic
// reference model and an in-order scoreboard.
module tb_ahead_sub32_pipe;

    typedef struct packed {
        logic [31:0] diff;
        logic        bout;
        logic        ovf;
        logic        zero;
    } exp_t;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    localparam int NV = 8;
    localparam logic [31:0] TA   [NV] = '{32'h00000005, 32'h00010000, 32'h00000000, 32'h80000000,
                                          32'h7FFFFFFF, 32'h12345678, 32'h12345678, 32'h00000000};
    localparam logic [31:0] TB   [NV] = '{32'h00000003, 32'h00000001, 32'h00000001, 32'h00000001,
                                          32'hFFFFFFFF, 32'h12345678, 32'h12345678, 32'h00000000};
    localparam logic        TBIN [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic [31:0] TD   [NV] = '{32'h00000002, 32'h0000FFFF, 32'hFFFFFFFF, 32'h7FFFFFFF,
                                          32'h80000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    localparam logic        TBO  [NV] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    localparam logic        TOV  [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic        TZ   [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   n_out;
    exp_t q[$];
    exp_t mon_e;

    ahead_sub32_pipe_if bus();

    ahead_sub32_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
        exp_t        e;
        logic [32:0] full;
        longint      sd;
        full   = {1'b0, a} - {1'b0, b} - 33'(bin);
        sd     = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
        e.diff = full[31:0];
        e.bout = full[32];
        e.ovf  = (sd > SMAX) || (sd < SMIN);
        e.zero = (full[31:0] == 32'h0);
        return e;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h00000000;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand();
        bus.a   = rand_word();
        bus.b   = ($urandom_range(0, 7) == 0) ? bus.a : rand_word();
        bus.bin = 1'($urandom_range(0, 1));
    endtask

    // Scoreboard: every accepted beat is modelled, every popped result compared in order.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                n_out++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_extra: got diff=%h with no beat outstanding", bus.diff);
                end else begin
                    mon_e = q.pop_front();
                    if ({bus.diff, bus.bout, bus.ovf, bus.zero} !== mon_e) begin
                        errors++;
                        $display("FAIL scoreboard: got diff=%h bout=%b ovf=%b zero=%b, expected diff=%h bout=%b ovf=%b zero=%b",
                                 bus.diff, bus.bout, bus.ovf, bus.zero,
                                 mon_e.diff, mon_e.bout, mon_e.ovf, mon_e.zero);
                    end else begin
                        $display("out %0d: diff=%h bout=%b ovf=%b zero=%b ok",
                                 n_out, bus.diff, bus.bout, bus.ovf, bus.zero);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.a, bus.b, bus.bin));
            end
        end
    end

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a         = 32'h1;
        bus.b         = 32'h0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, expected 0", bus.in_ready);
        end
        checks++;
        if ({bus.out_valid, bus.diff, bus.bout, bus.ovf, bus.zero} !== 36'h0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b diff=%h bout=%b ovf=%b zero=%b, expected all 0",
                     bus.out_valid, bus.diff, bus.bout, bus.ovf, bus.zero);
        end
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_single();
        for (int i = 0; i < NV; i++) begin
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b1;
            bus.a         = TA[i];
            bus.b         = TB[i];
            bus.bin       = TBIN[i];
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL single_in_ready[%0d]: got %b, expected 1", i, bus.in_ready);
            end
            tick();
            bus.in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_early[%0d]: out_valid=%b one cycle after accept, expected 0", i, bus.out_valid);
            end
            tick();
            @(negedge clk);
            checks++;
            if ({bus.out_valid, bus.diff, bus.bout, bus.ovf, bus.zero} !==
                {1'b1, TD[i], TBO[i], TOV[i], TZ[i]}) begin
                errors++;
                $display("FAIL single[%0d]: got valid=%b diff=%h bout=%b ovf=%b zero=%b, expected valid=1 diff=%h bout=%b ovf=%b zero=%b",
                         i, bus.out_valid, bus.diff, bus.bout, bus.ovf, bus.zero,
                         TD[i], TBO[i], TOV[i], TZ[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 22; i++) begin
            bus.in_valid = (i < 20);
            drive_rand();
            @(negedge clk);
            if (i < 20) begin
                checks++;
                if (bus.in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_in_ready[%0d]: got %b, expected 1", i, bus.in_ready);
                end
            end
            if (i >= 2) begin
                checks++;
                if (bus.out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_rate[%0d]: out_valid=%b, expected 1", i, bus.out_valid);
                end
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: out_valid=%b pending=%0d, expected 0 and 0", bus.out_valid, q.size());
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] ba [4];
        logic [31:0] bb [4];
        logic        bc [4];
        logic [31:0] held;
        int          idx;
        logic        acc;
        for (int k = 0; k < 4; k++) begin
            ba[k] = $urandom;
            bb[k] = $urandom;
            bc[k] = 1'($urandom_range(0, 1));
        end
        idx           = 0;
        held          = '0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            bus.in_valid = (idx < 4);
            bus.a   = ba[idx % 4];
            bus.b   = bb[idx % 4];
            bus.bin = bc[idx % 4];
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            checks++;
            if (bus.in_ready !== (c < 2)) begin
                errors++;
                $display("FAIL bp_in_ready[%0d]: got %b, expected %b", c, bus.in_ready, (c < 2));
            end
            if (c == 2) held = bus.diff;
            if (c > 2) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.diff !== held) begin
                    errors++;
                    $display("FAIL bp_hold[%0d]: valid=%b diff=%h, expected valid=1 diff=%h", c, bus.out_valid, bus.diff, held);
                end
            end
            tick();
            if (acc) idx++;
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bus.in_valid = (idx < 4);
            bus.a   = ba[idx % 4];
            bus.b   = bb[idx % 4];
            bus.bin = bc[idx % 4];
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (c < 4) begin
                checks++;
                if (bus.out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_drain_rate[%0d]: out_valid=%b, expected 1", c, bus.out_valid);
                end
            end
            if (c < 2) begin
                checks++;
                if (bus.in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_recover[%0d]: in_ready=%b, expected 1", c, bus.in_ready);
                end
            end
            tick();
            if (acc) idx++;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (idx != 4 || q.size() != 0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_complete: accepted=%0d pending=%0d valid=%b, expected 4, 0, 0", idx, q.size(), bus.out_valid);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            drive_rand();
            tick();
        end
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_in_ready: got %b, expected 0", bus.in_ready);
        end
        tick();
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.diff !== 32'h0) begin
            errors++;
            $display("FAIL midrst_clear: valid=%b diff=%h, expected 0 and 00000000", bus.out_valid, bus.diff);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_stale[%0d]: out_valid=%b, expected 0", i, bus.out_valid);
            end
        end
        tick();
        bus.in_valid = 1'b1;
        drive_rand();
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_accept: in_ready=%b, expected 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_early: out_valid=%b, expected 0", bus.out_valid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_latency: out_valid=%b, expected 1", bus.out_valid);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            drive_rand();
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() != 0; i++) tick();
        @(negedge clk);
        checks++;
        if (q.size() != 0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL random_drain: pending=%0d valid=%b, expected 0 and 0", q.size(), bus.out_valid);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        errors = 0;
        checks = 0;
        n_out  = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
